// File: rtl/product_checker_if.sv
// Handshake/bus bundle between a triple source and product_checker.
// Latency: none, wires only.
// Backpressure: the source holds a triple while in_ready=0; results are a one-cycle out_valid pulse.
// Ports: in_valid/in_ready/a/b/dut_product (source -> checker), out_valid/mismatch/golden (checker -> consumer).
interface product_checker_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   dut_product;
  logic                 out_valid;
  logic                 mismatch;
  logic [2*WIDTH-1:0]   golden;

  // master: the side that offers triples and consumes results
  modport master (
    output in_valid, a, b, dut_product,
    input  in_ready, out_valid, mismatch, golden
  );

  // slave: the checker
  modport slave (
    input  in_valid, a, b, dut_product,
    output in_ready, out_valid, mismatch, golden
  );
endinterface

// File: rtl/product_checker.sv
// Checks an array multiplier result against a serial shift-add reference product.
// Latency: accept at edge N -> out_valid visible after edge N+WIDTH+1; one check in flight.
// Backpressure: in_ready=1 only in IDLE; in_valid outside IDLE is ignored.
// Ports: clk, rst_n (sync, active-low), bus (product_checker_if.slave), clr,
//        err_count (saturating), alarm (sticky), first_a/first_b when PRODUCT_CHECKER_LOG_EN is defined.
// Option PRODUCT_CHECKER_LOG_EN: records the operands of the first mismatch after reset or clr.
module product_checker #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  product_checker_if.slave  bus,
  input  logic              clr,
  output logic [CNT_W-1:0]  err_count,
  output logic              alarm
`ifdef PRODUCT_CHECKER_LOG_EN
  ,
  output logic [WIDTH-1:0]  first_a,
  output logic [WIDTH-1:0]  first_b
`endif
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      mcand_q, mcand_d;     // multiplicand, shifted left each step
  logic [WIDTH-1:0]   mplier_q, mplier_d;   // multiplier, shifted right each step
  logic [PW-1:0]      acc_q, acc_d;
  logic [PW-1:0]      dut_q, dut_d;         // latched product under test
  logic [SW-1:0]      step_q, step_d;
  logic [PW-1:0]      golden_q, golden_d;
  logic               mismatch_q, mismatch_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic               alarm_q, alarm_d;
`ifdef PRODUCT_CHECKER_LOG_EN
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   first_a_q, first_a_d;
  logic [WIDTH-1:0]   first_b_q, first_b_d;
`endif

  logic               mis_now;
  logic [CNT_W-1:0]   err_base;
  logic               alarm_base;

  assign mis_now = (acc_q != dut_q);

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    dut_d       = dut_q;
    step_d      = step_q;
    golden_d    = golden_q;
    mismatch_d  = mismatch_q;
    out_valid_d = 1'b0;
`ifdef PRODUCT_CHECKER_LOG_EN
    a_d         = a_q;
    b_d         = b_q;
    first_a_d   = first_a_q;
    first_b_d   = first_b_q;
`endif

    // clr is applied first so a coincident DONE mismatch lands on a cleared counter
    err_base   = clr ? '0 : err_q;
    alarm_base = clr ? 1'b0 : alarm_q;
    err_d      = err_base;
    alarm_d    = alarm_base;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mcand_d  = {{WIDTH{1'b0}}, bus.a};
          mplier_d = bus.b;
          acc_d    = '0;
          step_d   = '0;
          dut_d    = bus.dut_product;
`ifdef PRODUCT_CHECKER_LOG_EN
          a_d      = bus.a;
          b_d      = bus.b;
`endif
          state_d  = BUSY;
        end
      end

      BUSY: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        step_d   = step_q + SW'(1);
        if (step_q == SW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // results become visible on the edge that leaves DONE
        out_valid_d = 1'b1;
        golden_d    = acc_q;
        mismatch_d  = mis_now;
        if (mis_now) begin
          err_d   = (&err_base) ? err_base : err_base + CNT_W'(1);
          alarm_d = 1'b1;
`ifdef PRODUCT_CHECKER_LOG_EN
          // alarm_base low means no mismatch seen since reset or (this) clr
          if (!alarm_base) begin
            first_a_d = a_q;
            first_b_d = b_q;
          end
`endif
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      dut_q       <= '0;
      step_q      <= '0;
      golden_q    <= '0;
      mismatch_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= '0;
      alarm_q     <= 1'b0;
`ifdef PRODUCT_CHECKER_LOG_EN
      a_q         <= '0;
      b_q         <= '0;
      first_a_q   <= '0;
      first_b_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      dut_q       <= dut_d;
      step_q      <= step_d;
      golden_q    <= golden_d;
      mismatch_q  <= mismatch_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      alarm_q     <= alarm_d;
`ifdef PRODUCT_CHECKER_LOG_EN
      a_q         <= a_d;
      b_q         <= b_d;
      first_a_q   <= first_a_d;
      first_b_q   <= first_b_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.golden    = golden_q;
  assign err_count     = err_q;
  assign alarm         = alarm_q;
`ifdef PRODUCT_CHECKER_LOG_EN
  assign first_a       = first_a_q;
  assign first_b       = first_b_q;
`endif

endmodule

// File: tb/tb_product_checker.sv
// Scoreboard bench for product_checker: driver pushes expected results, monitor pops on out_valid.
// Latency: checks out_valid arrives WIDTH+2 cycles after the cycle the triple was offered.
// Backpressure: driver only counts a triple as accepted when in_ready is high.
module tb_product_checker;

  localparam int W     = 16;
  localparam int PW    = 2 * W;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic [CNT_W-1:0] err_count;
  logic             alarm;
`ifdef PRODUCT_CHECKER_LOG_EN
  logic [W-1:0]     first_a;
  logic [W-1:0]     first_b;
`endif

  product_checker_if #(.WIDTH(W)) ifc ();

  product_checker #(.WIDTH(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (ifc.slave),
    .clr       (clr),
    .err_count (err_count),
    .alarm     (alarm)
`ifdef PRODUCT_CHECKER_LOG_EN
    ,
    .first_a   (first_a),
    .first_b   (first_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [PW-1:0] prod;
    logic [PW-1:0] exp;
    bit            clr_done;
    int            cyc;
  } item_t;

  item_t q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state, owned by the monitor except while nothing is in flight
  logic [CNT_W-1:0] m_err   = '0;
  logic             m_alarm = 1'b0;
  logic [W-1:0]     m_fa    = '0;
  logic [W-1:0]     m_fb    = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [PW-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return PW'(p);
  endfunction

  // monitor
  item_t mon_it;
  logic  mon_mm;
  always @(negedge clk) begin
    if (rst_n && ifc.out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", 64'(ifc.out_valid), 64'd0);
      end else begin
        mon_it = q.pop_front();
        mon_mm = (mon_it.exp != mon_it.prod);
        chk("latency", 64'(cyc - mon_it.cyc), 64'(W + 2));
        chk("golden", 64'(ifc.golden), 64'(mon_it.exp));
        chk("mismatch", 64'(ifc.mismatch), 64'(mon_mm));
        if (mon_it.clr_done) begin
          m_err   = '0;
          m_alarm = 1'b0;
        end
        if (mon_mm) begin
          if (!m_alarm) begin
            m_fa = mon_it.a;
            m_fb = mon_it.b;
          end
          m_alarm = 1'b1;
          if (m_err != {CNT_W{1'b1}}) m_err = m_err + 1'b1;
        end
        chk("err_count", 64'(err_count), 64'(m_err));
        chk("alarm", 64'(alarm), 64'(m_alarm));
`ifdef PRODUCT_CHECKER_LOG_EN
        chk("first_a", 64'(first_a), 64'(m_fa));
        chk("first_b", 64'(first_b), 64'(m_fb));
`endif
      end
    end
  end

  task automatic push_item(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [PW-1:0] p, input bit clr_done);
    item_t it;
    it.a = a; it.b = b; it.prod = p; it.exp = ref_product(a, b);
    it.clr_done = clr_done; it.cyc = cyc;
    q.push_back(it);
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!ifc.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ifc.in_ready) chk("ready_timeout", 64'(ifc.in_ready), 64'd1);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() > 0) begin
      chk("drain_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  64'(ifc.in_ready),  64'd1);
    chk({tag, "_out_valid"}, 64'(ifc.out_valid), 64'd0);
    chk({tag, "_mismatch"},  64'(ifc.mismatch),  64'd0);
    chk({tag, "_golden"},    64'(ifc.golden),    64'd0);
    chk({tag, "_err_count"}, 64'(err_count),     64'd0);
    chk({tag, "_alarm"},     64'(alarm),         64'd0);
`ifdef PRODUCT_CHECKER_LOG_EN
    chk({tag, "_first_a"},   64'(first_a),       64'd0);
    chk({tag, "_first_b"},   64'(first_b),       64'd0);
`endif
  endtask

  // One directed check; optionally pulses clr in the DONE cycle. Called at a negedge.
  task automatic one_check(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [PW-1:0] p, input bit clr_done);
    wait_ready();
    ifc.in_valid    = 1'b1;
    ifc.a           = a;
    ifc.b           = b;
    ifc.dut_product = p;
    push_item(a, b, p, clr_done);
    @(negedge clk);            // after accept edge N
    ifc.in_valid = 1'b0;
    repeat (W) @(negedge clk); // cycle after edge N+W: DONE
    clr = clr_done;
    @(negedge clk);            // out_valid cycle
    clr = 1'b0;
    @(negedge clk);
  endtask

  // in_valid held high with operands changing every cycle
  task automatic stream(input int n, input bit force_mm);
    int acc = 0;
    int last = -1;
    int t = 0;
    logic [W-1:0]  a, b;
    logic [PW-1:0] p, e;
    ifc.in_valid = 1'b1;
    while (acc < n && t < n * (W + 2) + 100) begin
      a = W'($urandom);
      b = W'($urandom);
      if ($urandom_range(0, 7) == 0) a = '1;
      e = ref_product(a, b);
      if (force_mm || $urandom_range(0, 1) == 1)
        p = e ^ (PW'(1) << $urandom_range(0, PW - 1));
      else
        p = e;
      ifc.a = a;
      ifc.b = b;
      ifc.dut_product = p;
      if (ifc.in_ready) begin
        if (last >= 0) chk("accept_spacing", 64'(cyc - last), 64'(W + 2));
        last = cyc;
        push_item(a, b, p, 1'b0);
        acc++;
      end
      @(negedge clk);
      t++;
    end
    ifc.in_valid = 1'b0;
    if (acc < n) chk("stream_timeout", 64'(acc), 64'(n));
  endtask

  initial begin
    rst_n           = 1'b0;
    clr             = 1'b0;
    ifc.in_valid    = 1'b0;
    ifc.a           = '0;
    ifc.b           = '0;
    ifc.dut_product = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // basic and full-width operands
    one_check(16'd3, 16'd5, 32'd15, 1'b0);
    one_check(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0);
    one_check(16'hFFFF, 16'hFFFF, 32'h0000FFFF, 1'b0);
    one_check(16'd2, 16'd2, 32'd5, 1'b0);
    // clr in the DONE cycle of a mismatch: clear then count
    one_check(16'd7, 16'd9, 32'd0, 1'b1);
    drain();

    // reset on the 5th BUSY cycle abandons the check
    wait_ready();
    ifc.in_valid    = 1'b1;
    ifc.a           = 16'h1234;
    ifc.b           = 16'h5678;
    ifc.dut_product = 32'h0;
    @(negedge clk);            // BUSY cycle 1
    ifc.in_valid = 1'b0;
    repeat (4) @(negedge clk); // BUSY cycle 5
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_err = '0; m_alarm = 1'b0; m_fa = '0; m_fb = '0;
    check_reset_outputs("busy_reset");
    repeat (W + 4) @(negedge clk);

    // mixed random traffic, then saturation
    stream(40, 1'b0);
    drain();
    stream(300, 1'b1);
    drain();
    repeat (2) @(negedge clk);
    chk("sat_err_count", 64'(err_count), 64'd255);
    chk("sat_alarm", 64'(alarm), 64'd1);

    // clr outside DONE
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_err = '0; m_alarm = 1'b0;
    chk("clr_err_count", 64'(err_count), 64'd0);
    chk("clr_alarm", 64'(alarm), 64'd0);
    @(negedge clk);
    chk("clr_hold_err_count", 64'(err_count), 64'd0);

    // after clr, a correct check must leave counters at zero and a bad one must count once
    one_check(16'd100, 16'd200, 32'd20000, 1'b0);
    one_check(16'h8000, 16'h0002, 32'h0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
